// File: rtl/hnf_tag_sram_ctrl_pkg.sv
// Shared sizes, FSM encoding and read latency for the HNF tag SRAM controller.
package hnf_tag_sram_ctrl_pkg;

    localparam int LOC_INDEX_WIDTH = 10;
    localparam int LOC_WAY_NUM     = 16;
    localparam int LOC_CLINE_WIDTH = 28;
    localparam int TAG_RD_LAT      = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/hnf_tag_sram_ctrl_if.sv
// Requester-side bundle of the tag SRAM controller: lookup, tag write, flush, response.
interface hnf_tag_sram_ctrl_if #(
    parameter int LOC_INDEX_WIDTH = hnf_tag_sram_ctrl_pkg::LOC_INDEX_WIDTH,
    parameter int LOC_WAY_NUM     = hnf_tag_sram_ctrl_pkg::LOC_WAY_NUM,
    parameter int LOC_CLINE_WIDTH = hnf_tag_sram_ctrl_pkg::LOC_CLINE_WIDTH
);
    logic                                   rd_req_valid;
    logic                                   rd_req_ready;
    logic [LOC_INDEX_WIDTH-1:0]             rd_req_index;
    logic                                   wr_req_valid;
    logic                                   wr_req_ready;
    logic [LOC_INDEX_WIDTH-1:0]             wr_req_index;
    logic [LOC_WAY_NUM-1:0]                 wr_req_ways;
    logic [LOC_CLINE_WIDTH-1:0]             wr_req_cline;
    logic                                   flush_req;
    logic                                   init_done;
    logic                                   rd_rsp_valid;
    logic [LOC_CLINE_WIDTH*LOC_WAY_NUM-1:0] rd_rsp_clines;

    modport master (
        output rd_req_valid, rd_req_index,
        output wr_req_valid, wr_req_index, wr_req_ways, wr_req_cline,
        output flush_req,
        input  rd_req_ready, wr_req_ready, init_done,
        input  rd_rsp_valid, rd_rsp_clines
    );

    modport slave (
        input  rd_req_valid, rd_req_index,
        input  wr_req_valid, wr_req_index, wr_req_ways, wr_req_cline,
        input  flush_req,
        output rd_req_ready, wr_req_ready, init_done,
        output rd_rsp_valid, rd_rsp_clines
    );

endinterface

// File: rtl/hnf_tag_sram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; pointer flips only on a contested grant.
module hnf_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rd_req,
    input  logic wr_req,
    output logic rd_gnt,
    output logic wr_gnt
);
    logic rr_ptr_q;

    assign rd_gnt = en & rd_req & (~wr_req | ~rr_ptr_q);
    assign wr_gnt = en & wr_req & (~rd_req |  rr_ptr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr_q <= 1'b0;
        else if (en & rd_req & wr_req)
            rr_ptr_q <= ~rr_ptr_q;
    end

endmodule

// File: rtl/hnf_tag_sram_ctrl.sv
// Tag SRAM sequencer: invalidate-all sweep, read/write arbitration, tracked read latency.
module hnf_tag_sram_ctrl #(
    parameter int LOC_INDEX_WIDTH = hnf_tag_sram_ctrl_pkg::LOC_INDEX_WIDTH,
    parameter int LOC_WAY_NUM     = hnf_tag_sram_ctrl_pkg::LOC_WAY_NUM,
    parameter int LOC_CLINE_WIDTH = hnf_tag_sram_ctrl_pkg::LOC_CLINE_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    hnf_tag_sram_ctrl_if.slave                     req,
    output logic [LOC_INDEX_WIDTH-1:0]             loc_index_q,
    output logic                                   loc_rd_en_q,
    output logic [LOC_WAY_NUM-1:0]                 loc_wr_ways_q,
    output logic [LOC_CLINE_WIDTH-1:0]             loc_wr_cline_q,
    input  logic [LOC_CLINE_WIDTH*LOC_WAY_NUM-1:0] loc_rd_clines_q
);
    import hnf_tag_sram_ctrl_pkg::*;

    localparam logic [LOC_INDEX_WIDTH-1:0] LAST_IDX = '1;

    state_e                     state_q;
    state_e                     state_d;
    logic [LOC_INDEX_WIDTH-1:0] cnt_q;
    logic                       run;
    logic                       rd_gnt;
    logic                       wr_gnt;
    logic [TAG_RD_LAT-1:0]      rsp_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: if (cnt_q == LAST_IDX) state_d = RUN;
            RUN:  if (req.flush_req)     state_d = INIT;
        endcase
    end

    always_comb begin
        run = (state_q == RUN);
    end

    assign req.init_done     = run;
    assign req.rd_req_ready  = rd_gnt;
    assign req.wr_req_ready  = wr_gnt;
    assign req.rd_rsp_valid  = rsp_vld_q[TAG_RD_LAT-1];
    assign req.rd_rsp_clines = loc_rd_clines_q;

    hnf_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (run),
        .rd_req (req.rd_req_valid),
        .wr_req (req.wr_req_valid),
        .rd_gnt (rd_gnt),
        .wr_gnt (wr_gnt)
    );

    // Counter sits at 0 in RUN so a flush always restarts the sweep at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (!run)
            cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loc_index_q    <= '0;
            loc_rd_en_q    <= 1'b0;
            loc_wr_ways_q  <= '0;
            loc_wr_cline_q <= '0;
        end else begin
            loc_rd_en_q   <= 1'b0;
            loc_wr_ways_q <= '0;
            if (!run) begin
                loc_index_q    <= cnt_q;
                loc_wr_ways_q  <= '1;
                loc_wr_cline_q <= '0;
            end else if (rd_gnt) begin
                loc_index_q <= req.rd_req_index;
                loc_rd_en_q <= 1'b1;
            end else if (wr_gnt) begin
                loc_index_q    <= req.wr_req_index;
                loc_wr_ways_q  <= req.wr_req_ways;
                loc_wr_cline_q <= req.wr_req_cline;
            end
        end
    end

    // Keeps shifting across a flush so in-flight reads still answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rsp_vld_q <= '0;
        else
            rsp_vld_q <= {rsp_vld_q[TAG_RD_LAT-2:0], rd_gnt};
    end

endmodule

// File: tb/tb_hnf_tag_sram_ctrl.sv
// Random and directed bench for hnf_tag_sram_ctrl against a set-level reference model.
module tb_hnf_tag_sram_ctrl;

    localparam int IW    = 3;
    localparam int WN    = 16;
    localparam int CW    = 28;
    localparam int DEPTH = 8;
    localparam int DW    = CW * WN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hnf_tag_sram_ctrl_if #(
        .LOC_INDEX_WIDTH (IW),
        .LOC_WAY_NUM     (WN),
        .LOC_CLINE_WIDTH (CW)
    ) bus ();

    logic [IW-1:0] loc_index_q;
    logic          loc_rd_en_q;
    logic [WN-1:0] loc_wr_ways_q;
    logic [CW-1:0] loc_wr_cline_q;
    logic [DW-1:0] loc_rd_clines_q = '0;

    hnf_tag_sram_ctrl #(
        .LOC_INDEX_WIDTH (IW),
        .LOC_WAY_NUM     (WN),
        .LOC_CLINE_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (bus.slave),
        .loc_index_q     (loc_index_q),
        .loc_rd_en_q     (loc_rd_en_q),
        .loc_wr_ways_q   (loc_wr_ways_q),
        .loc_wr_cline_q  (loc_wr_cline_q),
        .loc_rd_clines_q (loc_rd_clines_q)
    );

    // Tag SRAM stand-in: masked write, two-register read path.
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] sram_rd = '0;
    always @(posedge clk) begin
        for (int w = 0; w < WN; w++)
            if (loc_wr_ways_q[w]) sram[loc_index_q][w*CW +: CW] <= loc_wr_cline_q;
        if (loc_rd_en_q) sram_rd <= sram[loc_index_q];
        loc_rd_clines_q <= sram_rd;
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rsp_t          rsp_q[$];
    bit            m_run;
    bit            m_ptr;
    int            m_cnt;
    int            cyc;
    logic [IW-1:0] e_idx;
    logic          e_rd_en;
    logic [WN-1:0] e_ways;
    logic [CW-1:0] e_cline;
    int            n_chk;
    int            n_fail;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_ptr   = 1'b0;
        m_cnt   = 0;
        e_idx   = '0;
        e_rd_en = 1'b0;
        e_ways  = '0;
        e_cline = '0;
        rsp_q.delete();
    endtask

    task automatic check_rsp();
        bit exp_v;
        exp_v = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
        check("rsp_valid", DW'(bus.rd_rsp_valid), DW'(exp_v));
        if (exp_v) check("rsp_clines", bus.rd_rsp_clines, rsp_q[0].data);
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) void'(rsp_q.pop_front());
    endtask

    task automatic step(input bit rv, input logic [IW-1:0] ri,
                        input bit wv, input logic [IW-1:0] wi,
                        input logic [WN-1:0] ways, input logic [CW-1:0] cl,
                        input bit fl);
        bit er;
        bit ew;
        bus.rd_req_valid = rv;
        bus.rd_req_index = ri;
        bus.wr_req_valid = wv;
        bus.wr_req_index = wi;
        bus.wr_req_ways  = ways;
        bus.wr_req_cline = cl;
        bus.flush_req    = fl;
        #1;
        er = m_run && rv && (!wv || !m_ptr);
        ew = m_run && wv && (!rv || m_ptr);
        check("rd_ready", DW'(bus.rd_req_ready), DW'(er));
        check("wr_ready", DW'(bus.wr_req_ready), DW'(ew));
        check("init_done", DW'(bus.init_done), DW'(m_run));
        if (!m_run) begin
            e_idx   = m_cnt[IW-1:0];
            e_ways  = '1;
            e_cline = '0;
            e_rd_en = 1'b0;
            ref_mem[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) begin
                m_run = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            e_rd_en = 1'b0;
            e_ways  = '0;
            if (er) begin
                e_idx   = ri;
                e_rd_en = 1'b1;
                rsp_q.push_back('{cyc + 3, ref_mem[ri]});
            end else if (ew) begin
                e_idx   = wi;
                e_ways  = ways;
                e_cline = cl;
                for (int w = 0; w < WN; w++)
                    if (ways[w]) ref_mem[wi][w*CW +: CW] = cl;
            end
            if (rv && wv) m_ptr = !m_ptr;
            if (fl) m_run = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("loc_index", DW'(loc_index_q), DW'(e_idx));
        check("loc_rd_en", DW'(loc_rd_en_q), DW'(e_rd_en));
        check("loc_wr_ways", DW'(loc_wr_ways_q), DW'(e_ways));
        if (e_ways != '0) check("loc_wr_cline", DW'(loc_wr_cline_q), DW'(e_cline));
        check_rsp();
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++)
            step(busy, 3'd1, busy, 3'd2, 16'hffff, 28'hfff_ffff, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_index"}, DW'(loc_index_q), '0);
        check({tag, "_rd_en"}, DW'(loc_rd_en_q), '0);
        check({tag, "_ways"}, DW'(loc_wr_ways_q), '0);
        check({tag, "_cline"}, DW'(loc_wr_cline_q), '0);
        check({tag, "_readies"}, DW'({bus.rd_req_ready, bus.wr_req_ready}), '0);
        check({tag, "_init_done"}, DW'(bus.init_done), '0);
        check({tag, "_rsp_valid"}, DW'(bus.rd_rsp_valid), '0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_index = '0;
        bus.wr_req_valid = 1'b0;
        bus.wr_req_index = '0;
        bus.wr_req_ways  = '0;
        bus.wr_req_cline = '0;
        bus.flush_req    = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // power-up sweep, then a read of index 5
        idle(8, 1'b1);
        step(1'b1, 3'd5, 1'b0, 3'd0, '0, '0, 1'b0);
        idle(4, 1'b0);

        // contested grants alternate from the reset pointer
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'(i), 1'b1, 3'(i + 4), 16'(1 << i), 28'(i + 1), 1'b0);
        idle(4, 1'b0);

        // write then immediately read the same set
        step(1'b0, 3'd0, 1'b1, 3'd2, 16'h0004, 28'h123_4567, 1'b0);
        step(1'b1, 3'd2, 1'b0, 3'd0, '0, '0, 1'b0);
        idle(2, 1'b0);
        check("raw_way2", DW'(bus.rd_rsp_clines[2*CW +: CW]), DW'(28'h123_4567));
        check("raw_way1", DW'(bus.rd_rsp_clines[1*CW +: CW]), '0);
        idle(1, 1'b0);

        // back-to-back reads
        for (int i = 1; i <= 4; i++)
            step(1'b1, 3'(i), 1'b0, 3'd0, '0, '0, 1'b0);
        idle(4, 1'b0);

        // flush with two reads in flight, requests held during the sweep
        step(1'b1, 3'd4, 1'b0, 3'd0, '0, '0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 3'd0, '0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 3'd0, '0, '0, 1'b1);
        idle(9, 1'b1);
        idle(2, 1'b0);

        // random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            logic [WN-1:0] ways;
            ways = ($urandom_range(0, 7) == 0) ? '0 : WN'($urandom);
            step(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 1)),
                 3'($urandom), ways, CW'($urandom), ($urandom_range(0, 59) == 0));
        end
        idle(12, 1'b0);
        check("rsp_drain", DW'(rsp_q.size()), '0);

        // reset in the middle of a sweep
        step(1'b1, 3'd6, 1'b0, 3'd0, '0, '0, 1'b1);
        idle(4, 1'b0);
        check("sweep_idx3", DW'(loc_index_q), DW'(3'd3));
        rst = 1'b1;
        #1;
        check_zero("mid_sweep_rst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8, 1'b1);
        idle(1, 1'b0);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 1)),
                 3'($urandom), WN'($urandom), CW'($urandom), 1'b0);
        idle(4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hnf_tag_sram_ctrl.md
Name: hnf_tag_sram_ctrl

Overview:
Sequencer and arbiter in front of hnf_tag_sram. After reset, and on request, it sweeps every index and writes zero to all ways (invalidate-all). In normal operation it shares the single-port tag SRAM between a lookup read requester and a tag update/fill write requester. It also returns read data with a fixed, tracked latency.

Parameters:
LOC_INDEX_WIDTH, 10, tag SRAM index bits (depth = 2**LOC_INDEX_WIDTH).
LOC_WAY_NUM, 16, number of ways (one write-mask bit per way).
LOC_CLINE_WIDTH, 28, width of one way's tag entry.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
rd_req_valid  input  1  lookup request valid.
rd_req_ready  output  1  lookup request accepted when valid and ready.
rd_req_index  input  LOC_INDEX_WIDTH  lookup set index.
wr_req_valid  input  1  tag write request valid.
wr_req_ready  output  1  tag write accepted when valid and ready.
wr_req_index  input  LOC_INDEX_WIDTH  write set index.
wr_req_ways  input  LOC_WAY_NUM  one-hot or multi-hot way mask; all zero is legal (no-op write).
wr_req_cline  input  LOC_CLINE_WIDTH  entry written to every selected way.
flush_req  input  1  single-cycle pulse; requests invalidate-all.
init_done  output  1  high when in RUN; low during any sweep.
rd_rsp_valid  output  1  read data valid, exactly one cycle per accepted read.
rd_rsp_clines  output  LOC_CLINE_WIDTH*LOC_WAY_NUM  all ways of the read set; combinational copy of loc_rd_clines_q.
loc_index_q  output  LOC_INDEX_WIDTH  registered SRAM index.
loc_rd_en_q  output  1  registered read enable.
loc_wr_ways_q  output  LOC_WAY_NUM  registered SRAM way write mask.
loc_wr_cline_q  output  LOC_CLINE_WIDTH  registered SRAM write data.
loc_rd_clines_q  input  LOC_CLINE_WIDTH*LOC_WAY_NUM  registered SRAM read data.

Behaviour:
- Reset values: all loc_* outputs 0, rd_req_ready 0, wr_req_ready 0, init_done 0, rd_rsp_valid 0. The FSM resets to INIT with sweep counter 0 and rr_ptr 0.
- Reset asserted mid-sweep or mid-read: all state clears immediately. In-flight reads are dropped and produce no rd_rsp_valid.
- INIT state, one cycle per index:
  - loc_index_q <= counter; loc_wr_ways_q <= all ones; loc_wr_cline_q <= 0; loc_rd_en_q <= 0.
  - Both readies are low.
  - When the counter reaches 2**LOC_INDEX_WIDTH-1, that write is issued and the FSM moves to RUN next cycle. The counter then wraps to 0.
  - A full sweep is exactly 2**LOC_INDEX_WIDTH write cycles.
- RUN state: init_done = 1. At most one SRAM operation per cycle.
  - Only rd valid: rd_req_ready = 1.
  - Only wr valid: wr_req_ready = 1.
  - Both valid: grant the side selected by rr_ptr (0 = read, 1 = write), then toggle rr_ptr. rr_ptr only toggles on a contested grant.
  - Readies are combinational from the valids, rr_ptr and state. Exactly one ready is high when both valids are high; neither valid gives no readies.
- Accepted read at cycle T: in T+1, loc_index_q = index, loc_rd_en_q = 1, loc_wr_ways_q = 0. rd_rsp_valid is asserted in cycle T+3 via a 3-deep valid shift register. Back-to-back reads give back-to-back responses.
- Accepted write at cycle T: in T+1, loc_index_q = index, loc_wr_ways_q = wr_req_ways, loc_wr_cline_q = wr_req_cline, loc_rd_en_q = 0.
- Idle cycles: loc_wr_ways_q = 0 and loc_rd_en_q = 0. loc_index_q holds its value.
- Read-after-write to the same index accepted in consecutive cycles returns the new data; no forwarding is needed.
- flush_req:
  - In RUN: the FSM enters INIT next cycle and both readies drop that same next cycle.
  - Requests granted in the flush_req cycle still issue.
  - Reads already in flight complete with their normal rd_rsp_valid.
  - During INIT, flush_req is ignored.

Decomposition:
- Shared package (hnf_defines.v / hnf_param.v): LOC_INDEX_WIDTH, LOC_WAY_NUM, LOC_CLINE_WIDTH, the FSM state encodings (INIT = 1'b0, RUN = 1'b1) and TAG_RD_LAT = 3.
- One sub-module, hnf_rr_arb2: the 2-requester round-robin arbiter with its pointer register.

Test Plan:
1. LOC_INDEX_WIDTH=3, release rst -> 8 consecutive writes with ways=all ones, index 0..7, cline 0; init_done rises on the cycle after the index-7 write; then read index 5 -> rd_rsp_valid 3 cycles after acceptance, rd_rsp_clines = 0.
2. Write index 2, ways=0x0004, cline=0x1234567, then read index 2 the next cycle -> way 2 = 0x1234567, other ways 0.
3. rd_req_valid and wr_req_valid both held high for 4 cycles -> grants alternate R, W, R, W from reset pointer; exactly one ready per cycle.
4. 4 back-to-back reads of indices 1..4 -> 4 consecutive rd_rsp_valid cycles with data in order.
5. flush_req pulse while 2 reads are in flight -> both responses still arrive; init_done falls; full 8-cycle sweep follows; readies stay 0 until RUN.
6. Assert rst at sweep index 3 -> outputs 0 immediately; after release, the sweep restarts at index 0.
